// File: rtl/tx_char_queue_pkg.sv
// Shared types for the serial transmit path: sequencer states and character width.
// Combinational-only package; no storage, no flow control.
package serial_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } txq_state_t;

endpackage

// File: rtl/tx_char_queue_char_fifo.sv
// Character FIFO: head is a register read with zero latency; writes land after one edge.
// Writes while full are dropped and latch o_overflow; pops while empty are ignored.
module char_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [CHAR_W-1:0]        i_wr_data,
    input  logic                     i_pop,
    output logic [CHAR_W-1:0]        o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [CHAR_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // Fullness is judged before any same-cycle pop, so a write at full is always lost.
    assign w_push  = i_wr_en & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/tx_char_queue.sv
// Queues bytes and feeds them one at a time to the serial transmitter with a load pulse.
// Write-to-load is two edges; the next byte is loaded only after the transmitter's charSent rises.
module tx_char_queue
    import serial_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int LOAD_CYCLES = 1,
    parameter int TIMEOUT     = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wrEn,
    input  logic [CHAR_W-1:0]        i_wrData,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_timeoutErr,
    output logic                     o_load,
    output logic [CHAR_W-1:0]        o_parallelDataOut,
    output logic                     o_transmitEnable,
    input  logic                     i_charSent
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
    localparam bit             WDOG_EN   = (TIMEOUT != 0);

    txq_state_t        r_state;
    txq_state_t        w_state_nxt;
    logic [LCW-1:0]    r_load_cnt;
    logic [WDW-1:0]    r_wdog;
    logic              r_charSentQ;
    logic              r_timeout_err;

    logic              w_cs_rise;
    logic              w_wdog_hit;
    logic              w_wdog_fire;
    logic              w_pop;
    logic              w_more;
    logic              w_load;
    logic              w_tx_en;
    logic [CW-1:0]     w_count;

    char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_wrEn),
        .i_wr_data  (i_wrData),
        .i_pop      (w_pop),
        .o_head     (o_parallelDataOut),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (w_count),
        .o_overflow (o_overflow)
    );

    assign w_cs_rise  = i_charSent & ~r_charSentQ;
    assign w_wdog_hit = WDOG_EN && (r_wdog == WDOG_LAST);
    assign w_more     = |w_count[CW-1:1];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_wdog_fire = 1'b0;
        w_load      = 1'b0;
        w_tx_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_count != '0) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_load  = 1'b1;
                w_tx_en = 1'b1;
                if (r_load_cnt == LOAD_LAST) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_tx_en = 1'b1;
                // A completion wins over a watchdog expiry landing in the same cycle.
                if (w_cs_rise) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_more ? LOAD : IDLE;
                end else if (w_wdog_hit) begin
                    w_pop       = 1'b1;
                    w_wdog_fire = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_load_cnt    <= '0;
            r_wdog        <= '0;
            r_charSentQ   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_charSentQ <= i_charSent;
            if (r_state == LOAD && r_load_cnt != LOAD_LAST) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end else begin
                r_load_cnt <= '0;
            end
            // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
            if (r_state == WAIT) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
            if (w_wdog_fire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_count          = w_count;
    assign o_timeoutErr     = r_timeout_err;
    assign o_load           = w_load;
    assign o_transmitEnable = w_tx_en;

endmodule

// File: tb/tb_tx_char_queue.sv
// Directed bench for tx_char_queue: reset, single/back-to-back characters, overflow,
// ignored charSent edges, watchdog drop, and mid-character reset.
module tb_tx_char_queue;

    localparam int DEPTH       = 8;
    localparam int LOAD_CYCLES = 2;
    localparam int TIMEOUT     = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       char_sent = 1'b0;
    logic       full, empty, overflow, timeout_err, load, tx_en;
    logic [3:0] count;
    logic [7:0] pdo;

    int n_vec = 0;
    int n_err = 0;

    logic       mon_prev_load = 1'b0;
    logic [7:0] load_q[$];

    always #5 clk = ~clk;

    tx_char_queue #(
        .DEPTH       (DEPTH),
        .LOAD_CYCLES (LOAD_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_wrEn            (wr_en),
        .i_wrData          (wr_data),
        .o_full            (full),
        .o_empty           (empty),
        .o_count           (count),
        .o_overflow        (overflow),
        .o_timeoutErr      (timeout_err),
        .o_load            (load),
        .o_parallelDataOut (pdo),
        .o_transmitEnable  (tx_en),
        .i_charSent        (char_sent)
    );

    // Records the byte presented at each rising edge of load.
    always @(negedge clk) begin
        if (load && !mon_prev_load) load_q.push_back(pdo);
        mon_prev_load = load;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_en = 1'b0;
        char_sent = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_in_wait(input string tag);
        int k = 0;
        while (!(tx_en && !load) && k < 200) begin
            tick();
            k++;
        end
        check_vec(tag, {31'd0, (tx_en && !load)}, 32'd1);
    endtask

    initial begin
        int n;

        // Reset values
        do_reset();
        check_vec("rst_count", count, 0);
        check_vec("rst_empty", empty, 1);
        check_vec("rst_full", full, 0);
        check_vec("rst_ovf", overflow, 0);
        check_vec("rst_toerr", timeout_err, 0);
        check_vec("rst_load", load, 0);
        check_vec("rst_txen", tx_en, 0);
        check_vec("rst_pdo", pdo, 8'h00);

        // Single character: count after edge N, load from edge N+1 for LOAD_CYCLES
        write_byte(8'hA5);
        check_vec("t1_count1", count, 1);
        check_vec("t1_noload_yet", load, 0);
        tick();
        check_vec("t1_load_on", load, 1);
        check_vec("t1_pdo", pdo, 8'hA5);
        n = 0;
        while (load && n < 20) begin
            n++;
            tick();
        end
        check_vec("t1_load_len", n, LOAD_CYCLES);
        check_vec("t1_wait_txen", tx_en, 1);
        char_sent = 1'b1;
        tick();
        check_vec("t1_empty_after", empty, 1);
        check_vec("t1_idle_txen", tx_en, 0);
        tick();
        char_sent = 1'b0;
        tick();

        // Back-to-back characters with a 10-cycle charSent
        do_reset();
        load_q.delete();
        for (int i = 1; i <= 4; i++) write_byte(8'(i));
        for (int k = 0; k < 4; k++) begin
            wait_in_wait($sformatf("t2_wait%0d", k));
            check_vec($sformatf("t2_cnt_pre%0d", k), count, 4 - k);
            tick();
            tick();
            char_sent = 1'b1;
            tick();
            check_vec($sformatf("t2_cnt_post%0d", k), count, 3 - k);
            check_vec($sformatf("t2_reload%0d", k), load, (k < 3) ? 1 : 0);
            repeat (9) tick();
            char_sent = 1'b0;
            tick();
        end
        check_vec("t2_idle", tx_en, 0);
        check_vec("t2_empty", empty, 1);
        check_vec("t2_nloads", load_q.size(), 4);
        for (int k = 0; k < 4; k++)
            check_vec($sformatf("t2_byte%0d", k), (k < load_q.size()) ? load_q[k] : 8'hEE, k + 1);

        // Overflow at DEPTH=8
        do_reset();
        for (int i = 0; i < 9; i++) begin
            write_byte(8'h10 + 8'(i));
            if (i == 7) begin
                check_vec("t3_full8", full, 1);
                check_vec("t3_noovf8", overflow, 0);
            end
        end
        check_vec("t3_ovf", overflow, 1);
        check_vec("t3_count", count, 8);
        tick();
        tick();
        check_vec("t3_ovf_sticky", overflow, 1);

        // charSent rises in IDLE and in LOAD are ignored
        do_reset();
        write_byte(8'h55);
        char_sent = 1'b1;
        tick();
        check_vec("t4_idle_cnt", count, 1);
        check_vec("t4_load1", load, 1);
        char_sent = 1'b0;
        tick();
        check_vec("t4_load2", load, 1);
        char_sent = 1'b1;
        tick();
        check_vec("t4_load_cnt", count, 1);
        check_vec("t4_in_wait", {tx_en, load}, 2'b10);
        tick();
        check_vec("t4_held_cnt", count, 1);
        char_sent = 1'b0;
        tick();
        char_sent = 1'b1;
        tick();
        check_vec("t4_real_pop", count, 0);
        char_sent = 1'b0;
        tick();

        // Watchdog drop
        do_reset();
        write_byte(8'h3C);
        write_byte(8'h7E);
        wait_in_wait("t5_wait");
        n = 0;
        while (!timeout_err && n < 200) begin
            if (tx_en && !load) n++;
            tick();
        end
        check_vec("t5_wait_cycles", n, TIMEOUT);
        check_vec("t5_toerr", timeout_err, 1);
        check_vec("t5_count", count, 1);
        check_vec("t5_idle", tx_en, 0);
        check_vec("t5_head", pdo, 8'h7E);
        tick();
        check_vec("t5_reload", load, 1);
        check_vec("t5_reload_pdo", pdo, 8'h7E);

        // Reset during WAIT with three queued
        do_reset();
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        wait_in_wait("t6_wait");
        check_vec("t6_pre_cnt", count, 3);
        rst = 1'b0;
        tick();
        check_vec("t6_cnt", count, 0);
        check_vec("t6_txen", tx_en, 0);
        check_vec("t6_load", load, 0);
        rst = 1'b1;
        tick();
        char_sent = 1'b1;
        tick();
        tick();
        check_vec("t6_post_cnt", count, 0);
        check_vec("t6_post_txen", tx_en, 0);
        check_vec("t6_post_empty", empty, 1);
        char_sent = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
